// File: rtl/spotlight_mixer.sv
// Three-stage per-pixel lighting mixer: NUM_LIGHTS circular lights, a rectangular dark window
// and a frame-paced ambient fade. Define SPOTLIGHT_SOFT_EDGE_EN for a soft half-bright light rim.
module spotlight_mixer #(
    parameter int NUM_LIGHTS = 2,
    parameter int COORD_W    = 9,
    parameter int LIGHT_OFS  = 5,
    parameter int RADIUS_SQ  = 200
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dark_req,
    input  logic                          frame_tick,
    input  logic                          in_valid,
    input  logic [COORD_W-1:0]            in_x,
    input  logic [COORD_W-1:0]            in_y,
    input  logic [11:0]                   in_pixel,
    input  logic [NUM_LIGHTS*COORD_W-1:0] light_x,
    input  logic [NUM_LIGHTS*COORD_W-1:0] light_y,
    input  logic [NUM_LIGHTS-1:0]         light_en,
    input  logic [COORD_W-1:0]            win_x0,
    input  logic [COORD_W-1:0]            win_x1,
    input  logic [COORD_W-1:0]            win_y0,
    input  logic [COORD_W-1:0]            win_y1,
    output logic                          out_valid,
    output logic [11:0]                   out_pixel,
    output logic [3:0]                    dark_level,
    output logic                          fade_busy
);

    localparam int DW   = COORD_W + 1;   // one extra bit so light centre + offset never wraps
    localparam int SQ_W = 2 * DW + 1;
    localparam logic [DW-1:0]   OFS  = DW'(LIGHT_OFS);
    localparam logic [SQ_W-1:0] R_SQ = SQ_W'(RADIUS_SQ);
`ifdef SPOTLIGHT_SOFT_EDGE_EN
    localparam logic [SQ_W-1:0] R_SQ2 = SQ_W'(2 * RADIUS_SQ);
`endif

    typedef enum logic [1:0] {
        ST_LIT,
        ST_FADE_OUT,
        ST_DARK,
        ST_FADE_IN
    } fade_state_t;

    fade_state_t state;

    function automatic logic [DW-1:0] abs_dist(input logic [COORD_W-1:0] p,
                                                input logic [COORD_W-1:0] l);
        logic [DW-1:0] pe;
        logic [DW-1:0] c;
        pe = {1'b0, p};
        c  = {1'b0, l} + OFS;
        return (pe >= c) ? (pe - c) : (c - pe);
    endfunction

    function automatic logic [3:0] scale_ch(input logic [3:0] ch, input logic [3:0] lvl);
        logic [7:0] prod;
        prod = {4'd0, ch} * ({4'd0, lvl} + 8'd1);
        return 4'(prod >> 4);
    endfunction

    // ---------------- Stage 1: input capture ----------------
    logic                          s1_valid;
    logic [11:0]                   s1_pixel;
    logic [COORD_W-1:0]            s1_x, s1_y;
    logic [NUM_LIGHTS*COORD_W-1:0] s1_lx, s1_ly;
    logic [NUM_LIGHTS-1:0]         s1_en;
    logic [COORD_W-1:0]            s1_wx0, s1_wx1, s1_wy0, s1_wy1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pixel <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_lx    <= '0;
            s1_ly    <= '0;
            s1_en    <= '0;
            s1_wx0   <= '0;
            s1_wx1   <= '0;
            s1_wy0   <= '0;
            s1_wy1   <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_pixel <= in_pixel;
            s1_x     <= in_x;
            s1_y     <= in_y;
            s1_lx    <= light_x;
            s1_ly    <= light_y;
            s1_en    <= light_en;
            s1_wx0   <= win_x0;
            s1_wx1   <= win_x1;
            s1_wy0   <= win_y0;
            s1_wy1   <= win_y1;
        end
    end

    // ---------------- Stage 2: per-light distances and window test ----------------
    logic [DW-1:0] dx_c [NUM_LIGHTS];
    logic [DW-1:0] dy_c [NUM_LIGHTS];
    logic          in_win_c;

    always_comb begin
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            dx_c[i] = abs_dist(s1_x, s1_lx[i*COORD_W +: COORD_W]);
            dy_c[i] = abs_dist(s1_y, s1_ly[i*COORD_W +: COORD_W]);
        end
    end

    // An inverted bound pair yields an empty window, so everything passes through.
    assign in_win_c = (s1_x >= s1_wx0) && (s1_x <= s1_wx1) &&
                      (s1_y >= s1_wy0) && (s1_y <= s1_wy1);

    logic                  s2_valid;
    logic [11:0]           s2_pixel;
    logic                  s2_in_win;
    logic [NUM_LIGHTS-1:0] s2_en;
    logic [DW-1:0]         s2_dx [NUM_LIGHTS];
    logic [DW-1:0]         s2_dy [NUM_LIGHTS];

    // NOTE: the distance arrays are a handful of flops, so they are reset like every other pipe register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_pixel  <= '0;
            s2_in_win <= 1'b0;
            s2_en     <= '0;
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                s2_dx[i] <= '0;
                s2_dy[i] <= '0;
            end
        end else begin
            s2_valid  <= s1_valid;
            s2_pixel  <= s1_pixel;
            s2_in_win <= in_win_c;
            s2_en     <= s1_en;
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                s2_dx[i] <= dx_c[i];
                s2_dy[i] <= dy_c[i];
            end
        end
    end

    // ---------------- Stage 3: square, compare, mix ----------------
    logic        lit_c;
`ifdef SPOTLIGHT_SOFT_EDGE_EN
    logic        near_c;
`endif
    logic [11:0] mixed_c;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        logic [2*DW-1:0] sq_x;
        logic [2*DW-1:0] sq_y;
        logic [SQ_W-1:0] dist_sq;
        lit_c   = 1'b0;
`ifdef SPOTLIGHT_SOFT_EDGE_EN
        near_c  = 1'b0;
`endif
        sq_x    = '0;
        sq_y    = '0;
        dist_sq = '0;
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            sq_x    = s2_dx[i] * s2_dx[i];
            sq_y    = s2_dy[i] * s2_dy[i];
            dist_sq = {1'b0, sq_x} + {1'b0, sq_y};
            if (s2_en[i] && (dist_sq < R_SQ)) lit_c = 1'b1;
`ifdef SPOTLIGHT_SOFT_EDGE_EN
            if (s2_en[i] && (dist_sq < R_SQ2)) near_c = 1'b1;
`endif
        end
    end

    always_comb begin
        logic [3:0] ch;
        logic [3:0] sc;
        mixed_c = s2_pixel;
        ch      = '0;
        sc      = '0;
        if (s2_in_win && (dark_level != 4'hF) && !lit_c) begin
            for (int c = 0; c < 3; c++) begin
                ch = s2_pixel[c*4 +: 4];
                sc = scale_ch(ch, dark_level);
`ifdef SPOTLIGHT_SOFT_EDGE_EN
                if (near_c && ((ch >> 1) > sc)) sc = ch >> 1;
`endif
                mixed_c[c*4 +: 4] = sc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else begin
            out_valid <= s2_valid;
            out_pixel <= s2_valid ? mixed_c : 12'h000;
        end
    end

    // ---------------- Ambient fade controller ----------------
    // A direction reversal takes priority over a coincident tick and holds the level for that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LIT;
            dark_level <= 4'hF;
            fade_busy  <= 1'b0;
        end else begin
            case (state)
                ST_LIT: begin
                    if (dark_req) begin
                        state     <= ST_FADE_OUT;
                        fade_busy <= 1'b1;
                    end
                end
                ST_FADE_OUT: begin
                    if (!dark_req) begin
                        state <= ST_FADE_IN;
                    end else if (frame_tick) begin
                        if (dark_level <= 4'd1) begin
                            dark_level <= 4'd0;
                            state      <= ST_DARK;
                            fade_busy  <= 1'b0;
                        end else begin
                            dark_level <= dark_level - 4'd1;
                        end
                    end
                end
                ST_DARK: begin
                    if (!dark_req) begin
                        state     <= ST_FADE_IN;
                        fade_busy <= 1'b1;
                    end
                end
                ST_FADE_IN: begin
                    if (dark_req) begin
                        state <= ST_FADE_OUT;
                    end else if (frame_tick) begin
                        if (dark_level >= 4'd14) begin
                            dark_level <= 4'hF;
                            state      <= ST_LIT;
                            fade_busy  <= 1'b0;
                        end else begin
                            dark_level <= dark_level + 4'd1;
                        end
                    end
                end
                default: begin
                    state      <= ST_LIT;
                    dark_level <= 4'hF;
                    fade_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spotlight_mixer.sv
// Scoreboard bench for spotlight_mixer: directed scenarios plus randomized traffic
// checked against a target-tracking fade model and an arithmetic lighting model.
module tb_spotlight_mixer;

    localparam int NL  = 2;
    localparam int CW  = 9;
    localparam int OFS = 5;
    localparam int RSQ = 200;
    localparam int HN  = 16384;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           dark_req = 1'b0;
    logic           frame_tick = 1'b0;
    logic           in_valid = 1'b0;
    logic [CW-1:0]  in_x = '0, in_y = '0;
    logic [11:0]    in_pixel = '0;
    logic [NL*CW-1:0] light_x = '0, light_y = '0;
    logic [NL-1:0]  light_en = '0;
    logic [CW-1:0]  win_x0 = '0, win_x1 = '0, win_y0 = '0, win_y1 = '0;
    logic           out_valid;
    logic [11:0]    out_pixel;
    logic [3:0]     dark_level;
    logic           fade_busy;

    always #5 clk = ~clk;

    spotlight_mixer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dark_req   (dark_req),
        .frame_tick (frame_tick),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_pixel   (in_pixel),
        .light_x    (light_x),
        .light_y    (light_y),
        .light_en   (light_en),
        .win_x0     (win_x0),
        .win_x1     (win_x1),
        .win_y0     (win_y0),
        .win_y1     (win_y1),
        .out_valid  (out_valid),
        .out_pixel  (out_pixel),
        .dark_level (dark_level),
        .fade_busy  (fade_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          out_cyc;
        logic [11:0] pix;
        logic        inwin;
        logic        lit;
        logic        near;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         m_lvl = 15;
    logic       m_dir = 1'b0;   // 1 = heading towards dark
    logic       m_busy = 1'b0;
    int         level_hist [HN];

    function automatic exp_t classify(input int ocyc);
        exp_t e;
        int dx, dy, d;
        e.out_cyc = ocyc;
        e.pix     = in_pixel;
        e.lit     = 1'b0;
        e.near    = 1'b0;
        e.inwin   = (in_x >= win_x0) && (in_x <= win_x1) && (in_y >= win_y0) && (in_y <= win_y1);
        for (int i = 0; i < NL; i++) begin
            if (light_en[i]) begin
                dx = int'(in_x) - (int'(light_x[i*CW +: CW]) + OFS);
                dy = int'(in_y) - (int'(light_y[i*CW +: CW]) + OFS);
                d  = dx * dx + dy * dy;
                if (d < RSQ)     e.lit  = 1'b1;
                if (d < 2 * RSQ) e.near = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic logic [11:0] model_mix(input exp_t e, input int lvl);
        logic [11:0] r;
        int ch, s;
        if (!e.inwin || lvl == 15 || e.lit) return e.pix;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            ch = int'(e.pix[c*4 +: 4]);
            s  = (ch * (lvl + 1)) / 16;
`ifdef SPOTLIGHT_SOFT_EDGE_EN
            if (e.near && (ch / 2) > s) s = ch / 2;
`endif
            r[c*4 +: 4] = 4'(s);
        end
        return r;
    endfunction

    // Model advances on every clock edge from the same inputs the DUT samples.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_lvl  = 15;
            m_dir  = 1'b0;
            m_busy = 1'b0;
            sb.delete();
        end else begin
            if (in_valid) sb.push_back(classify(cyc + 2));
            if (dark_req != m_dir) begin
                m_dir  = dark_req;
                m_busy = 1'b1;
            end else if (m_busy && frame_tick) begin
                if (m_dir) m_lvl = (m_lvl == 0) ? 0 : m_lvl - 1;
                else       m_lvl = (m_lvl == 15) ? 15 : m_lvl + 1;
                if (m_lvl == (m_dir ? 0 : 15)) m_busy = 1'b0;
            end
        end
        level_hist[cyc % HN] = m_lvl;
    end

    // Monitor: compares level/busy every cycle and pops the scoreboard on each output pixel.
    always @(negedge clk) begin
        exp_t e;
        logic exp_valid;
        if (rst_n) begin
            check("dark_level", 32'(dark_level), 32'(m_lvl));
            check("fade_busy", 32'(fade_busy), 32'(m_busy));
            exp_valid = (sb.size() > 0) && (sb[0].out_cyc == cyc);
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            if (out_valid && sb.size() > 0) begin
                e = sb.pop_front();
                check("latency", 32'(cyc), 32'(e.out_cyc));
                check("out_pixel", 32'(out_pixel), 32'(model_mix(e, level_hist[(cyc - 1) % HN])));
            end else if (!out_valid) begin
                if (exp_valid) void'(sb.pop_front());
                check("idle_pixel", 32'(out_pixel), 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int x, input int y, input logic [11:0] p);
        in_valid = 1'b1;
        in_x     = CW'(x);
        in_y     = CW'(y);
        in_pixel = p;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        win_x0 = 9'd60;  win_x1 = 9'd285;
        win_y0 = 9'd30;  win_y1 = 9'd235;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_pixel", 32'(out_pixel), 32'h0);
        check("rst_dark_level", 32'(dark_level), 32'hF);
        check("rst_fade_busy", 32'(fade_busy), 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Full-bright pass-through inside the window.
        send(100, 100, 12'hFFF);
        repeat (4) @(negedge clk);

        // Fade fully dark.
        dark_req = 1'b1;
        @(negedge clk);
        repeat (15) tick();
        check("dark_reached_level", 32'(dark_level), 32'h0);
        check("dark_reached_busy", 32'(fade_busy), 32'h0);

        // Lit, unlit and outside-window pixels while dark.
        light_x  = 18'd95;
        light_y  = 18'd95;
        light_en = 2'b01;
        send(100, 100, 12'hFFF);
        send(130, 130, 12'hFFF);
        send(10, 10, 12'hFFF);
        repeat (4) @(negedge clk);

        // Fade back to lit, then down to 8 and reverse on a tick cycle.
        dark_req = 1'b0;
        @(negedge clk);
        repeat (15) tick();
        check("relit_level", 32'(dark_level), 32'hF);
        dark_req = 1'b1;
        @(negedge clk);
        repeat (7) tick();
        check("fade_to_8", 32'(dark_level), 32'h8);
        dark_req   = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("reversal_hold_level", 32'(dark_level), 32'h8);
        check("reversal_busy", 32'(fade_busy), 32'h1);
        tick();
        check("fade_in_step", 32'(dark_level), 32'h9);

        // Down to level 7 and scale an unlit window pixel.
        dark_req = 1'b1;
        @(negedge clk);
        repeat (2) tick();
        check("level_7", 32'(dark_level), 32'h7);
        light_en = 2'b00;
        send(200, 200, 12'hF84);
        repeat (4) @(negedge clk);

        // Randomized traffic with occasional reconfiguration.
        light_en = 2'b11;
        light_x  = {9'd140, 9'd60};
        light_y  = {9'd50, 9'd120};
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 63) == 0) dark_req = ~dark_req;
            frame_tick = ($urandom_range(0, 7) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_x       = CW'($urandom_range(40, 190));
            in_y       = CW'($urandom_range(20, 170));
            in_pixel   = 12'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                light_x  = {CW'($urandom_range(40, 180)), CW'($urandom_range(40, 180))};
                light_y  = {CW'($urandom_range(20, 160)), CW'($urandom_range(20, 160))};
                light_en = 2'($urandom);
                win_x0   = CW'($urandom_range(30, 200));
                win_x1   = CW'($urandom_range(30, 200));
                win_y0   = CW'($urandom_range(10, 180));
                win_y1   = CW'($urandom_range(10, 180));
            end
            @(negedge clk);
        end
        in_valid   = 1'b0;
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);

        // Back-to-back stream with one bubble, then reset while pixels are in flight.
        dark_req = 1'b1;
        win_x0 = 9'd0;   win_x1 = 9'd300;
        win_y0 = 9'd0;   win_y1 = 9'd230;
        for (int n = 0; n < 8; n++) begin
            in_valid = (n != 3);
            in_x     = CW'(50 + n * 7);
            in_y     = CW'(60 + n * 5);
            in_pixel = 12'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'h0);
        check("async_rst_out_pixel", 32'(out_pixel), 32'h0);
        check("async_rst_dark_level", 32'(dark_level), 32'hF);
        check("async_rst_fade_busy", 32'(fade_busy), 32'h0);
        in_valid = 1'b0;
        dark_req = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send(120, 90, 12'hABC);
        send(121, 90, 12'h123);
        repeat (6) @(negedge clk);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
